// File: rtl/fft_stream_pkg.sv
// Shared types and constants for the FFT stream blocks: group FSM states,
// lane-index width helper and the lane-count output width.
package fft_stream_pkg;

  typedef enum logic {
    GATHER = 1'b0,
    HOLD   = 1'b1
  } grp_state_e;

  localparam int LANE_CNT_W = 3;

  function automatic int lane_idx_w(input int lanes);
    return (lanes <= 2) ? 1 : $clog2(lanes);
  endfunction

endpackage

// File: rtl/fft_lane_gather_group_reg.sv
// fft_group_reg: output holding register for one gathered group with
// valid/ready handshake; flags a stall when the held group is not consumed.
module fft_group_reg
  import fft_stream_pkg::*;
#(
  parameter int bit_width = 16,
  parameter int LANES     = 2
`ifdef FFT_LANE_GATHER_TWIDDLE_PASS_EN
  , parameter int word_length_tw = 14
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_load,
  input  logic [LANES*bit_width-1:0]   i_re,
  input  logic [LANES*bit_width-1:0]   i_im,
  input  logic                         i_last,
  input  logic [LANE_CNT_W-1:0]        i_lanes,
`ifdef FFT_LANE_GATHER_TWIDDLE_PASS_EN
  input  logic [word_length_tw-1:0]    i_cos,
  input  logic [word_length_tw-1:0]    i_sin,
  output logic [word_length_tw-1:0]    o_cos,
  output logic [word_length_tw-1:0]    o_sin,
`endif
  input  logic                         i_out_ready,
  output logic                         o_valid,
  output logic                         o_last,
  output logic [LANE_CNT_W-1:0]        o_lanes,
  output logic [LANES*bit_width-1:0]   o_re,
  output logic [LANES*bit_width-1:0]   o_im,
  output logic                         o_stall
);

  grp_state_e r_state;
  logic       r_valid;
  logic       w_cap;

  // A new group may only be captured when the register is empty or draining.
  assign w_cap   = i_load && ((r_state == GATHER) || i_out_ready);
  assign o_stall = (r_state == HOLD) && !i_out_ready;
  assign o_valid = r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= GATHER;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        GATHER: begin
          if (i_load) begin
            r_state <= HOLD;
            r_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (i_out_ready && !i_load) begin
            r_state <= GATHER;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= GATHER;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_re    <= '0;
      o_im    <= '0;
      o_last  <= 1'b0;
      o_lanes <= '0;
`ifdef FFT_LANE_GATHER_TWIDDLE_PASS_EN
      o_cos   <= '0;
      o_sin   <= '0;
`endif
    end else if (w_cap) begin
      o_re    <= i_re;
      o_im    <= i_im;
      o_last  <= i_last;
      o_lanes <= i_lanes;
`ifdef FFT_LANE_GATHER_TWIDDLE_PASS_EN
      o_cos   <= i_cos;
      o_sin   <= i_sin;
`endif
    end
  end

endmodule

// File: rtl/fft_lane_gather.sv
// Serial-to-parallel gatherer: packs LANES complex samples into one group.
// Optional twiddle pass-through enabled by FFT_LANE_GATHER_TWIDDLE_PASS_EN.
module fft_lane_gather
  import fft_stream_pkg::*;
#(
  parameter int bit_width      = 16,
  parameter int word_length_tw = 14,
  parameter int LANES          = 2
) (
  input  logic                        clk,
  input  logic                        rst,
`ifdef FFT_LANE_GATHER_TWIDDLE_PASS_EN
  input  logic [word_length_tw-1:0]   cos_data,
  input  logic [word_length_tw-1:0]   sin_data,
  output logic [word_length_tw-1:0]   o_cos_data,
  output logic [word_length_tw-1:0]   o_sin_data,
`endif
  input  logic signed [bit_width-1:0] Re_i,
  input  logic signed [bit_width-1:0] Im_i,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic [LANES*bit_width-1:0]  Re_o,
  output logic [LANES*bit_width-1:0]  Im_o,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic [LANE_CNT_W-1:0]       out_lanes
);

  localparam int IDX_W = lane_idx_w(LANES);

  if (!(LANES == 2 || LANES == 4) || word_length_tw < 1) begin : g_bad_cfg
    $error("fft_lane_gather: LANES must be 2 or 4 and word_length_tw positive");
  end

  logic [IDX_W-1:0]             r_cnt;
  logic signed [bit_width-1:0]  r_re_g [LANES];
  logic signed [bit_width-1:0]  r_im_g [LANES];
  logic                         w_accept;
  logic                         w_cnt_full;
  logic                         w_complete;
  logic                         w_stall;
  logic [LANES*bit_width-1:0]   w_re_grp;
  logic [LANES*bit_width-1:0]   w_im_grp;
  logic [LANE_CNT_W-1:0]        w_lanes;

  assign w_cnt_full = (r_cnt == IDX_W'(LANES - 1));
  // A flushing sample completes a group too, so it must not overwrite a held one.
  assign in_ready   = !(w_stall && (w_cnt_full || (in_valid && in_last)));
  assign w_accept   = in_valid && in_ready;
  assign w_complete = w_accept && (w_cnt_full || in_last);
  assign w_lanes    = LANE_CNT_W'(r_cnt) + LANE_CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_complete) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && !w_complete) begin
      r_re_g[r_cnt] <= Re_i;
      r_im_g[r_cnt] <= Im_i;
    end
  end

  // Lanes past the completing sample are stale from earlier groups; zero them.
  always_comb begin
    w_re_grp = '0;
    w_im_grp = '0;
    for (int k = 0; k < LANES; k++) begin
      if (k < int'(r_cnt)) begin
        w_re_grp[k*bit_width +: bit_width] = r_re_g[k];
        w_im_grp[k*bit_width +: bit_width] = r_im_g[k];
      end else if (k == int'(r_cnt)) begin
        w_re_grp[k*bit_width +: bit_width] = Re_i;
        w_im_grp[k*bit_width +: bit_width] = Im_i;
      end
    end
  end

`ifdef FFT_LANE_GATHER_TWIDDLE_PASS_EN
  logic [word_length_tw-1:0] r_cos_l0;
  logic [word_length_tw-1:0] r_sin_l0;
  logic [word_length_tw-1:0] w_cos_grp;
  logic [word_length_tw-1:0] w_sin_grp;

  always_ff @(posedge clk) begin
    if (w_accept && (r_cnt == '0)) begin
      r_cos_l0 <= cos_data;
      r_sin_l0 <= sin_data;
    end
  end

  assign w_cos_grp = (r_cnt == '0) ? cos_data : r_cos_l0;
  assign w_sin_grp = (r_cnt == '0) ? sin_data : r_sin_l0;
`endif

  fft_group_reg #(
    .bit_width      (bit_width),
    .LANES          (LANES)
`ifdef FFT_LANE_GATHER_TWIDDLE_PASS_EN
    , .word_length_tw (word_length_tw)
`endif
  ) u_group_reg (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_complete),
    .i_re        (w_re_grp),
    .i_im        (w_im_grp),
    .i_last      (in_last),
    .i_lanes     (w_lanes),
`ifdef FFT_LANE_GATHER_TWIDDLE_PASS_EN
    .i_cos       (w_cos_grp),
    .i_sin       (w_sin_grp),
    .o_cos       (o_cos_data),
    .o_sin       (o_sin_data),
`endif
    .i_out_ready (out_ready),
    .o_valid     (out_valid),
    .o_last      (out_last),
    .o_lanes     (out_lanes),
    .o_re        (Re_o),
    .o_im        (Im_o),
    .o_stall     (w_stall)
  );

endmodule
